data_loader_serializer: RTL and testbench

//  Write-direction counterpart of the byte-wise unload path. Accepts 32-bit APF bridge

---
 rtl/data_loader_serializer.sv | 197 +++++++++++++++++++
 tb/tb_data_loader_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_loader_serializer.sv
`default_nettype none
// ============================================================================
// Module   : data_loader_serializer
// Purpose  : Buffers 32-bit bridge write words in a small FIFO and replays each
//            one as four byte writes at consecutive addresses, with an idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module data_loader_serializer #(
  parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h0,
  parameter int         WRITE_DELAY          = 2,
  parameter int         FIFO_DEPTH           = 4
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        bridge_wr,
  input  logic        bridge_endian_little,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  output logic        write_en,
  output logic [27:0] write_addr,
  output logic [7:0]  write_data,
  output logic        busy,
  output logic        overflow
);

  localparam int                 c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 c_cnt_w    = c_ptr_w + 1;
  localparam int                 c_entry_w  = 61;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [3:0]         c_gap_last = 4'((WRITE_DELAY > 0) ? WRITE_DELAY - 1 : 0);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_write = 2'd1;
  localparam logic [1:0] c_st_gap   = 2'd2;

  // FIFO entry layout: {addr[27:0], data[31:0], little}
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_overflow;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [1:0]           r_k;
  logic [3:0]           r_gap;
  logic [27:0]          r_base;
  logic [31:0]          r_word;
  logic                 r_little;

  logic                 r_write_en;
  logic [27:0]          r_write_addr;
  logic [7:0]           r_write_data;

  logic                 w_match;
  logic                 w_full;
  logic                 w_fifo_nempty;
  logic                 w_pop;
  logic                 w_push;
  logic [c_entry_w-1:0] w_head;
  logic                 w_wr_en_nxt;
  logic [27:0]          w_addr_nxt;
  logic [7:0]           w_data_nxt;

  assign w_match       = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
  assign w_full        = (r_count == c_depth);
  assign w_fifo_nempty = (r_count != '0);
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign w_push        = w_match && (!w_full || w_pop);
  assign w_head        = r_mem[r_rd_ptr];

  always_ff @(posedge clk_74a) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bridge_addr[27:0], bridge_wr_data, bridge_endian_little};
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (w_match && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = c_st_write;
        end
      end
      c_st_write: begin
        if (WRITE_DELAY != 0) begin
          w_state_nxt = c_st_gap;
        end else if (r_k != 2'd3) begin
          w_state_nxt = c_st_write;
        end else if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = c_st_write;
        end else begin
          w_state_nxt = c_st_idle;
        end
      end
      c_st_gap: begin
        if (r_gap == c_gap_last) begin
          w_state_nxt = (r_k != 2'd3) ? c_st_write : c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Byte strobe and its address/data are registered, so they trail the WRITE state by one cycle.
  always_comb begin
    w_wr_en_nxt = (r_state == c_st_write);
    w_addr_nxt  = r_base + {26'd0, r_k};
    if (r_little) begin
      case (r_k)
        2'd0:    w_data_nxt = r_word[7:0];
        2'd1:    w_data_nxt = r_word[15:8];
        2'd2:    w_data_nxt = r_word[23:16];
        default: w_data_nxt = r_word[31:24];
      endcase
    end else begin
      case (r_k)
        2'd0:    w_data_nxt = r_word[31:24];
        2'd1:    w_data_nxt = r_word[23:16];
        2'd2:    w_data_nxt = r_word[15:8];
        default: w_data_nxt = r_word[7:0];
      endcase
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_k          <= 2'd0;
      r_gap        <= 4'd0;
      r_base       <= 28'd0;
      r_word       <= 32'd0;
      r_little     <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_addr <= 28'd0;
      r_write_data <= 8'd0;
    end else begin
      if (w_pop) begin
        r_base   <= w_head[60:33];
        r_word   <= w_head[32:1];
        r_little <= w_head[0];
        r_k      <= 2'd0;
      end else if ((w_state_nxt == c_st_write) && (r_state != c_st_idle)) begin
        r_k <= r_k + 2'd1;
      end
      r_gap      <= (r_state == c_st_gap) ? r_gap + 4'd1 : 4'd0;
      r_write_en <= w_wr_en_nxt;
      if (w_wr_en_nxt) begin
        r_write_addr <= w_addr_nxt;
        r_write_data <= w_data_nxt;
      end
    end
  end

  assign write_en   = r_write_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign overflow   = r_overflow;
  assign busy       = w_fifo_nempty || (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_data_loader_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_loader_serializer
// Purpose  : Scoreboard bench for data_loader_serializer (directed + random words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_loader_serializer;

  localparam int c_wd = 2;

  logic        clk;
  logic        reset_n;
  logic        bridge_wr;
  logic        bridge_endian_little;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        write_en;
  logic [27:0] write_addr;
  logic [7:0]  write_data;
  logic        busy;
  logic        overflow;

  data_loader_serializer #(
    .ADDRESS_MASK_UPPER_4 (4'h0),
    .WRITE_DELAY          (c_wd),
    .FIFO_DEPTH           (4)
  ) dut (
    .clk_74a              (clk),
    .reset_n              (reset_n),
    .bridge_wr            (bridge_wr),
    .bridge_endian_little (bridge_endian_little),
    .bridge_addr          (bridge_addr),
    .bridge_wr_data       (bridge_wr_data),
    .write_en             (write_en),
    .write_addr           (write_addr),
    .write_data           (write_data),
    .busy                 (busy),
    .overflow             (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] addr;
    logic [7:0]  data;
    logic [1:0]  k;
  } exp_t;

  exp_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: each accepted word becomes four (address, byte) writes.
  task automatic model_word(input logic [31:0] a, input logic [31:0] d, input logic little);
    exp_t e;
    if (a[31:28] != 4'h0) return;
    for (int k = 0; k < 4; k++) begin
      e.addr = a[27:0] + 28'(k);
      e.data = little ? 8'(d >> (8 * k)) : 8'(d >> (24 - 8 * k));
      e.k    = 2'(k);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic little);
    @(negedge clk);
    bridge_wr            = 1'b1;
    bridge_addr          = a;
    bridge_wr_data       = d;
    bridge_endian_little = little;
    model_word(a, d, little);
    @(negedge clk);
    bridge_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      #2;
      if (busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: every write_en pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   low_cnt;
    low_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (write_en === 1'b1) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h data=%h required no write (t=%0t)",
                   write_addr, write_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(write_addr), 32'(e.addr));
          chk("write_data", 32'(write_data), 32'(e.data));
          if (e.k != 2'd0) chk("byte_gap", 32'(low_cnt), 32'(c_wd));
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
    int          n;
    int          target;
    bit          seen;

    reset_n              = 1'b0;
    bridge_wr            = 1'b0;
    bridge_endian_little = 1'b0;
    bridge_addr          = 32'd0;
    bridge_wr_data       = 32'd0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_write_en", 32'(write_en), 32'd0);
    chk("reset_write_addr", 32'(write_addr), 32'd0);
    chk("reset_write_data", 32'(write_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Little-endian word with latency check: strobe sampled at edge N, write_en after N+2.
    bridge_wr            = 1'b1;
    bridge_addr          = 32'h0000_000C;
    bridge_wr_data       = 32'hDDCC_BBAA;
    bridge_endian_little = 1'b1;
    model_word(32'h0000_000C, 32'hDDCC_BBAA, 1'b1);
    @(negedge clk);
    bridge_wr = 1'b0;
    @(posedge clk);
    #2;
    chk("latency_n1_write_en", 32'(write_en), 32'd0);
    chk("latency_n1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    chk("latency_n2_write_en", 32'(write_en), 32'd1);
    wait_drain("drain_little", 100);

    send(32'h0000_0124, 32'hAABB_CCDD, 1'b0);
    wait_drain("drain_big", 100);

    // Upper nibble mismatch: ignored entirely.
    send(32'h1000_0000, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      chk("mismatch_busy", 32'(busy), 32'd0);
    end
    chk("mismatch_overflow", 32'(overflow), 32'd0);

    send(32'h0FFF_FFFE, 32'h4433_2211, 1'b1);
    wait_drain("drain_wrap", 100);

    for (int b = 0; b < 20; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[31:28] = 4'h0;
        if ($urandom_range(0, 4) == 0) a[27:0] = 28'hFFF_FFFC + 28'($urandom_range(0, 3));
        d = $urandom;
        l = 1'($urandom_range(0, 1));
        send(a, d, l);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain("drain_random", 300);
    end
    chk("random_overflow", 32'(overflow), 32'd0);

    // Six back-to-back strobes into a depth-4 FIFO: the sixth is dropped.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("overflow_before_drop", 32'(overflow), 32'd0);
      a = 32'h0000_0100 + 32'(i * 16);
      d = $urandom;
      l = 1'(i & 1);
      bridge_wr            = 1'b1;
      bridge_addr          = a;
      bridge_wr_data       = d;
      bridge_endian_little = l;
      if (i < 5) model_word(a, d, l);
      @(negedge clk);
    end
    bridge_wr = 1'b0;
    chk("overflow_set", 32'(overflow), 32'd1);
    wait_drain("drain_overflow", 300);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset mid-word with more words queued.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = 32'h0000_0200 + 32'(i * 4);
      d = $urandom;
      bridge_wr            = 1'b1;
      bridge_addr          = a;
      bridge_wr_data       = d | 32'h0101_0101;
      bridge_endian_little = 1'b1;
      model_word(a, d | 32'h0101_0101, 1'b1);
      @(negedge clk);
    end
    bridge_wr = 1'b0;
    target = n_writes + 2;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (n_writes >= target) seen = 1'b1;
    end
    chk("second_byte_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_write_en", 32'(write_en), 32'd0);
    chk("async_reset_write_addr", 32'(write_addr), 32'd0);
    chk("async_reset_write_data", 32'(write_data), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_overflow", 32'(overflow), 32'd0);
    target = n_writes;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_overflow", 32'(overflow), 32'd0);
    chk("post_reset_no_writes", 32'(n_writes), 32'(target));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
